// File: rtl/mdio_regs.sv
// mdio_regs: Clause 22 management register file sitting behind the MDIO
// serial front end as a single-beat Wishbone slave.
//
// Registers: 0 BMCR, 1 BMSR, 2 PHYID1, 3 PHYID2,
//            16 false-carrier count, 17 symbol-error count.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cyc, stb, we        Wishbone cycle / strobe / write-enable
//   addr, data_write    register address and write data
//   data_read, ack, err read data (valid with ack), completion, error (always 0)
//   link_status         current PMA link state
//   false_carrier       one-clock event pulse
//   symbol_error        one-clock event pulse
//   loopback, pdown, isolate, duplex, coltest   BMCR control bits
//   phy_reset           high while a software reset is in progress
//
// Handshake: a request is cyc && stb && !ack. It is accepted on that clock
// and ack is high for exactly one cycle on the following clock, with
// data_read registered alongside it. A master holding stb sees an ack every
// other clock; ack is never high on two consecutive clocks.

module mdio_regs #(
    parameter logic [21:0] OUI          = 22'h000000,
    parameter logic [5:0]  MODEL        = 6'h00,
    parameter logic [3:0]  REVISION     = 4'h0,
    parameter int          RESET_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    output logic        ack,
    output logic        err,
    input  logic        link_status,
    input  logic        false_carrier,
    input  logic        symbol_error,
    output logic        loopback,
    output logic        pdown,
    output logic        isolate,
    output logic        duplex,
    output logic        coltest,
    output logic        phy_reset
);

    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0] RC_LOAD = CW'(RESET_CYCLES - 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_SRESET = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_rst_cnt;
    logic          r_ack;
    logic [15:0]   r_data_read;
    logic          r_phy_reset;
    logic          r_loopback, r_pdown, r_isolate, r_duplex, r_coltest;
    logic          r_link_latch;
    logic [15:0]   r_fc_cnt, r_se_cnt;

    logic          w_req, w_rd, w_wr;
    logic          w_sreset_go, w_hold;
    logic          w_rd_bmsr, w_rd_fc, w_rd_se;
    logic [15:0]   w_rdata;

    assign w_req = cyc && stb && !r_ack;
    assign w_rd  = w_req && !we;
    assign w_wr  = w_req && we;

    assign w_sreset_go = w_wr && (addr == 5'd0) && data_write[15] && (r_state == ST_NORMAL);
    // Counters and link latch are forced to their reset values on the entry
    // clock and for as long as the software reset lasts.
    assign w_hold = w_sreset_go || (r_state == ST_SRESET);

    assign w_rd_bmsr = w_rd && (addr == 5'd1);
    assign w_rd_fc   = w_rd && (addr == 5'd16);
    assign w_rd_se   = w_rd && (addr == 5'd17);

    always_comb begin
        w_rdata = 16'h0000;
        case (addr)
            5'd0:    w_rdata = {(r_state == ST_SRESET), r_loopback, 1'b1, 1'b0,
                                r_pdown, r_isolate, 1'b0, r_duplex, r_coltest, 7'b0};
            5'd1:    w_rdata = {1'b0, 1'b1, 1'b1, 10'b0, r_link_latch, 1'b0, 1'b1};
            5'd2:    w_rdata = OUI[21:6];
            5'd3:    w_rdata = {OUI[5:0], MODEL, REVISION};
            5'd16:   w_rdata = r_fc_cnt;
            5'd17:   w_rdata = r_se_cnt;
            default: w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_NORMAL;
            r_rst_cnt    <= '0;
            r_ack        <= 1'b0;
            r_data_read  <= 16'h0000;
            r_phy_reset  <= 1'b0;
            r_loopback   <= 1'b0;
            r_pdown      <= 1'b0;
            r_isolate    <= 1'b0;
            r_duplex     <= 1'b0;
            r_coltest    <= 1'b0;
            r_link_latch <= 1'b1;
            r_fc_cnt     <= 16'h0000;
            r_se_cnt     <= 16'h0000;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_data_read <= w_rdata;
            end

            case (r_state)
                ST_NORMAL: begin
                    if (w_sreset_go) begin
                        r_state     <= ST_SRESET;
                        r_rst_cnt   <= RC_LOAD;
                        r_phy_reset <= 1'b1;
                        r_loopback  <= 1'b0;
                        r_pdown     <= 1'b0;
                        r_isolate   <= 1'b0;
                        r_duplex    <= 1'b0;
                        r_coltest   <= 1'b0;
                    end else if (w_wr && (addr == 5'd0)) begin
                        r_loopback <= data_write[14];
                        r_pdown    <= data_write[11];
                        r_isolate  <= data_write[10];
                        r_duplex   <= data_write[8];
                        r_coltest  <= data_write[7];
                    end
                end
                ST_SRESET: begin
                    // Entry loads RESET_CYCLES-1, so phy_reset spans
                    // exactly RESET_CYCLES clocks.
                    if (r_rst_cnt == '0) begin
                        r_state     <= ST_NORMAL;
                        r_phy_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_NORMAL;
                    r_phy_reset <= 1'b0;
                end
            endcase

            if (w_hold) begin
                r_link_latch <= 1'b1;
                r_fc_cnt     <= 16'h0000;
                r_se_cnt     <= 16'h0000;
            end else begin
                // Latching-low link: a drop clears it, a BMSR read reloads it.
                if (!link_status) begin
                    r_link_latch <= 1'b0;
                end else if (w_rd_bmsr) begin
                    r_link_latch <= 1'b1;
                end

                // Clear-on-read; an event on the read clock survives as 1.
                if (w_rd_fc) begin
                    r_fc_cnt <= {15'b0, false_carrier};
                end else if (false_carrier && (r_fc_cnt != 16'hFFFF)) begin
                    r_fc_cnt <= r_fc_cnt + 16'd1;
                end

                if (w_rd_se) begin
                    r_se_cnt <= {15'b0, symbol_error};
                end else if (symbol_error && (r_se_cnt != 16'hFFFF)) begin
                    r_se_cnt <= r_se_cnt + 16'd1;
                end
            end
        end
    end

    assign ack       = r_ack;
    assign data_read = r_data_read;
    assign err       = 1'b0;
    assign phy_reset = r_phy_reset;
    assign loopback  = r_loopback;
    assign pdown     = r_pdown;
    assign isolate   = r_isolate;
    assign duplex    = r_duplex;
    assign coltest   = r_coltest;

endmodule

// File: tb/tb_mdio_regs.sv
// Self-checking bench for mdio_regs: directed vector table, hand-written
// multi-cycle sequences, and a randomized phase against a behavioural model.

module tb_mdio_regs;

    localparam logic [21:0] P_OUI   = 22'h2AAAAA;
    localparam logic [5:0]  P_MODEL = 6'h15;
    localparam logic [3:0]  P_REV   = 4'h3;
    localparam int          P_RC    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [4:0]  addr;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic        ack, err;
    logic        link_status, false_carrier, symbol_error;
    logic        loopback, pdown, isolate, duplex, coltest, phy_reset;

    mdio_regs #(
        .OUI(P_OUI), .MODEL(P_MODEL), .REVISION(P_REV), .RESET_CYCLES(P_RC)
    ) dut (
        .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
        .data_write(data_write), .data_read(data_read), .ack(ack), .err(err),
        .link_status(link_status), .false_carrier(false_carrier),
        .symbol_error(symbol_error), .loopback(loopback), .pdown(pdown),
        .isolate(isolate), .duplex(duplex), .coltest(coltest),
        .phy_reset(phy_reset)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Counts clocks (at negedge) during which phy_reset is high.
    int phy_hi_total = 0;
    always @(negedge clk) if (phy_reset === 1'b1) phy_hi_total++;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; data_write = '0;
        false_carrier = 1'b0; symbol_error = 1'b0; link_status = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // One transaction: request for one clock, expect ack on the next clock
    // for exactly one cycle. fc/se are event pulses on the accept clock.
    task automatic bus(input logic w, input logic [4:0] a, input logic [15:0] d,
                       input logic fc, input logic se, output logic [15:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; data_write = d;
        false_carrier = fc; symbol_error = se;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; false_carrier = 1'b0; symbol_error = 1'b0;
        check16("ack_rise", {15'b0, ack}, 16'd1);
        check16("err_zero", {15'b0, err}, 16'd0);
        rd = data_read;
        @(posedge clk); #1;
        check16("ack_fall", {15'b0, ack}, 16'd0);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [15:0] exp);
        logic [15:0] rd;
        bus(1'b0, a, 16'h0, 1'b0, 1'b0, rd);
        check16(name, rd, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        logic [15:0] rd;
        bus(1'b1, a, d, 1'b0, 1'b0, rd);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_ctrl;   // BMCR read/write bits in their register positions
    logic        m_latch;
    int          m_fc, m_se;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] m_read(input logic [4:0] a);
        logic [21:0] oui;
        oui = P_OUI;
        case (a)
            5'd0:    m_read = m_ctrl | 16'h2000;
            5'd1:    m_read = m_latch ? 16'h6005 : 16'h6001;
            5'd2:    m_read = oui[21:6];
            5'd3:    m_read = {oui[5:0], P_MODEL, P_REV};
            5'd16:   m_read = 16'(m_fc);
            5'd17:   m_read = 16'(m_se);
            default: m_read = 16'h0000;
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[20];

    initial begin
        logic [15:0] rd;
        int          guard;
        int          base;

        vt[0]  = '{1'b0, 5'd2,  16'h0000, 16'hAAAA};
        vt[1]  = '{1'b0, 5'd3,  16'h0000, 16'hA953};
        vt[2]  = '{1'b0, 5'd0,  16'h0000, 16'h2000};
        vt[3]  = '{1'b0, 5'd1,  16'h0000, 16'h6005};
        vt[4]  = '{1'b0, 5'd16, 16'h0000, 16'h0000};
        vt[5]  = '{1'b0, 5'd17, 16'h0000, 16'h0000};
        vt[6]  = '{1'b0, 5'd5,  16'h0000, 16'h0000};
        vt[7]  = '{1'b0, 5'd31, 16'h0000, 16'h0000};
        vt[8]  = '{1'b1, 5'd1,  16'hFFFF, 16'h0000};
        vt[9]  = '{1'b0, 5'd1,  16'h0000, 16'h6005};
        vt[10] = '{1'b1, 5'd3,  16'h0000, 16'h0000};
        vt[11] = '{1'b0, 5'd3,  16'h0000, 16'hA953};
        vt[12] = '{1'b1, 5'd0,  16'h4580, 16'h0000};
        vt[13] = '{1'b0, 5'd0,  16'h0000, 16'h6580};
        vt[14] = '{1'b1, 5'd0,  16'h0800, 16'h0000};
        vt[15] = '{1'b0, 5'd0,  16'h0000, 16'h2800};
        vt[16] = '{1'b1, 5'd0,  16'h7FFF, 16'h0000};
        vt[17] = '{1'b0, 5'd0,  16'h0000, 16'h6D80};
        vt[18] = '{1'b1, 5'd0,  16'h0000, 16'h0000};
        vt[19] = '{1'b0, 5'd0,  16'h0000, 16'h2000};

        // ---- reset state ----
        do_reset();
        check16("rst_ack",       {15'b0, ack}, 16'd0);
        check16("rst_data_read", data_read, 16'h0000);
        check16("rst_phy_reset", {15'b0, phy_reset}, 16'd0);
        check16("rst_ctrl", {11'b0, loopback, pdown, isolate, duplex, coltest}, 16'd0);
        check16("rst_err",       {15'b0, err}, 16'd0);

        // ---- table ----
        for (int i = 0; i < 20; i++) begin
            bus(vt[i].w, vt[i].a, vt[i].d, 1'b0, 1'b0, rd);
            if (!vt[i].w) begin
                check16($sformatf("vec%0d_read", i), rd, vt[i].exp);
            end else if (vt[i].a == 5'd0) begin
                check16($sformatf("vec%0d_ctrl", i),
                        {11'b0, loopback, pdown, isolate, duplex, coltest},
                        {11'b0, vt[i].d[14], vt[i].d[11], vt[i].d[10], vt[i].d[8], vt[i].d[7]});
            end
        end

        // ---- held strobe: ack on every other clock ----
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 5'd2;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            check16($sformatf("held_ack%0d", i), {15'b0, ack}, (i % 2 == 1) ? 16'd1 : 16'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        check16("held_data", data_read, 16'hAAAA);
        idle(1);

        // ---- latching-low link ----
        link_status = 1'b0;
        idle(1);
        link_status = 1'b1;
        rd_chk("link_first", 5'd1, 16'h6001);
        rd_chk("link_second", 5'd1, 16'h6005);

        // ---- counters: clear-on-read with event on the read clock ----
        false_carrier = 1'b1;
        idle(3);
        false_carrier = 1'b0;
        bus(1'b0, 5'd16, 16'h0, 1'b1, 1'b0, rd);
        check16("fc_preclear", rd, 16'd3);
        rd_chk("fc_after_evt", 5'd16, 16'd1);
        rd_chk("fc_cleared", 5'd16, 16'd0);
        symbol_error = 1'b1;
        idle(2);
        symbol_error = 1'b0;
        rd_chk("se_count", 5'd17, 16'd2);
        rd_chk("se_cleared", 5'd17, 16'd0);

        // ---- saturation ----
        false_carrier = 1'b1;
        idle(70000);
        false_carrier = 1'b0;
        rd_chk("fc_saturate", 5'd16, 16'hFFFF);
        rd_chk("fc_sat_clear", 5'd16, 16'h0000);

        // ---- software reset ----
        wr(5'd0, 16'h4000);
        check16("pre_sreset_lb", {15'b0, loopback}, 16'd1);
        base = phy_hi_total;
        wr(5'd0, 16'h8000);
        check16("sreset_phy_hi", {15'b0, phy_reset}, 16'd1);
        check16("sreset_lb_clr", {15'b0, loopback}, 16'd0);
        rd_chk("sreset_bmcr", 5'd0, 16'hA000);
        wr(5'd0, 16'h4000);
        rd_chk("sreset_wr_ign", 5'd0, 16'hA000);
        bus(1'b0, 5'd16, 16'h0, 1'b1, 1'b0, rd);
        check16("sreset_cnt_held", rd, 16'h0000);
        guard = 0;
        while (phy_reset && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check16("sreset_end", {15'b0, phy_reset}, 16'd0);
        idle(1);
        check16("sreset_len", 16'(phy_hi_total - base), 16'(P_RC));
        rd_chk("post_sreset_bmcr", 5'd0, 16'h2000);
        rd_chk("post_sreset_fc", 5'd16, 16'h0000);

        // ---- rst with a pending request and loopback set ----
        wr(5'd0, 16'h4000);
        false_carrier = 1'b1;
        idle(2);
        false_carrier = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 5'd2; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        check16("rst_mid_ack", {15'b0, ack}, 16'd0);
        check16("rst_mid_lb", {15'b0, loopback}, 16'd0);
        check16("rst_mid_phy", {15'b0, phy_reset}, 16'd0);
        check16("rst_mid_data", data_read, 16'h0000);
        rd_chk("rst_mid_fc", 5'd16, 16'h0000);

        // ---- rst during software reset ----
        wr(5'd0, 16'h8000);
        idle(4);
        check16("sr_rst_before", {15'b0, phy_reset}, 16'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check16("sr_rst_phy", {15'b0, phy_reset}, 16'd0);
        rd_chk("sr_rst_bmcr", 5'd0, 16'h2000);
        idle(20);
        check16("sr_rst_stay", {15'b0, phy_reset}, 16'd0);

        // ---- randomized phase against the model ----
        do_reset();
        m_ctrl = 16'h0000; m_latch = 1'b1; m_fc = 0; m_se = 0;
        begin
            logic        prev_req, req, w, fc, se, lk, was_read;
            logic [4:0]  a;
            logic [15:0] d;
            prev_req = 1'b0;
            was_read = 1'b0;
            for (int s = 0; s < 3000; s++) begin
                lk  = ($urandom_range(0, 15) != 0);
                fc  = ($urandom_range(0, 3) == 0);
                se  = ($urandom_range(0, 3) == 0);
                req = !prev_req && ($urandom_range(0, 1) == 1);
                w   = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 7))
                    0: a = 5'd0;
                    1: a = 5'd1;
                    2: a = 5'd2;
                    3: a = 5'd3;
                    4: a = 5'd16;
                    5: a = 5'd17;
                    default: a = 5'($urandom_range(0, 31));
                endcase
                d = 16'($urandom_range(0, 65535));
                if (a == 5'd0) d[15] = 1'b0;

                cyc = req; stb = req; we = w; addr = a; data_write = d;
                link_status = lk; false_carrier = fc; symbol_error = se;

                if (req && !w) exp_q.push_back(m_read(a));
                if (!lk) m_latch = 1'b0;
                else if (req && !w && a == 5'd1) m_latch = 1'b1;
                if (req && !w && a == 5'd16) m_fc = fc ? 1 : 0;
                else if (fc) m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
                if (req && !w && a == 5'd17) m_se = se ? 1 : 0;
                else if (se) m_se = (m_se < 65535) ? m_se + 1 : 65535;
                if (req && w && a == 5'd0) m_ctrl = d & 16'h4D80;
                was_read = req && !w;

                @(posedge clk); #1;
                check16("rand_ack", {15'b0, ack}, {15'b0, req});
                if (ack && was_read) begin
                    if (exp_q.size() == 0) begin
                        check16("rand_queue_empty", 16'd0, 16'd1);
                    end else begin
                        check16($sformatf("rand_read_a%0d", a), data_read, exp_q.pop_front());
                    end
                end
                check16("rand_ctrl", {11'b0, loopback, pdown, isolate, duplex, coltest},
                        {11'b0, m_ctrl[14], m_ctrl[11], m_ctrl[10], m_ctrl[8], m_ctrl[7]});
                prev_req = req;
            end
            cyc = 1'b0; stb = 1'b0; false_carrier = 1'b0; symbol_error = 1'b0;
            link_status = 1'b1;
            idle(1);
            check16("rand_queue_drained", 16'(exp_q.size()), 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
